// File: rtl/instr_prefetch.sv
// Instruction prefetch: sequential halfword fetch from a synchronous ROM into a PC-tagged FIFO.
// Define INSTR_PREFETCH_STATS_EN to build the fetch/flush statistics counters.
module instr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [31:0] BOOT_PC = {RESET_PC[31:1], 1'b0};

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic             rsp_pending_q, rsp_pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W:0]   occupancy_d;
    logic             issue, push, pop, has_entry;
    logic             redirect_pc_lsb_unused;
    entry_t           fifo_mem [DEPTH];
    entry_t           head_entry;

    assign redirect_pc_lsb_unused = redirect_pc[0];

    assign has_entry  = (count_q != '0);
    assign head_entry = fifo_mem[head_q];
    assign issue      = (state_q == RUN) && !redirect;
    assign push       = rsp_pending_q && !redirect;
    assign pop        = instr_valid && instr_ready;

    assign imem_en     = issue;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = has_entry && !redirect;
    // NOTE: the storage array is not reset; the head is masked to zero while empty instead.
    assign instr       = has_entry ? head_entry.instr : '0;
    assign instr_pc    = has_entry ? head_entry.pc : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        rsp_pending_d = 1'b0;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        occupancy_d   = '0;

        if (redirect) begin
            // The in-flight response and all buffered entries belong to the old stream.
            fetch_pc_d = {redirect_pc[31:1], 1'b0};
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            state_d    = RUN;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd2;
                rsp_pending_d = 1'b1;
                rsp_pc_d      = fetch_pc_q;
            end
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);

            // Stop issuing once buffered plus in-flight entries would fill the FIFO.
            occupancy_d = {1'b0, count_d} + {{CNT_W{1'b0}}, rsp_pending_d};
            if (state_q == BOOT)                         state_d = RUN;
            else if (occupancy_d == (CNT_W + 1)'(DEPTH)) state_d = HOLD;
            else                                         state_d = RUN;
        end
    end

    // NOTE: registers are updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= BOOT_PC;
            rsp_pc_q      <= '0;
            rsp_pending_q <= 1'b0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            rsp_pending_q <= rsp_pending_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail_q] <= '{instr: imem_rdata, pc: rsp_pc_q};
    end

`ifdef INSTR_PREFETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (pop) fetch_count_d = fetch_count_q + 32'd1;
        // A redirect only counts as a flush when it actually discards something.
        if (redirect && (has_entry || rsp_pending_q)) flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`else
    assign fetch_count = 32'h0;
    assign flush_count = 32'h0;
`endif

    // The issue gate keeps count + rsp_pending <= DEPTH, so a push never meets a full FIFO.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        push |-> (count_q != CNT_W'(DEPTH)));

endmodule
